// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, addresses the combinational ROM and
// fills the IF/ID register, with stall, redirect/flush and halt handling.
// Ports: clk, rst_n; stall_i, halt_i, redirect_i, redirect_pc_i from the
// pipeline; inst_i from the ROM, rom_addr_o to it; if_id_* towards decode;
// misalign_o flags a truncated redirect target; fetch_cnt_o counts captures.
module inst_fetch #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INST_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [INST_W-1:0]  NOP      = INST_W'(32'h0000_0013),
  parameter int unsigned        CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              halt_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [ADDR_W-1:0] if_id_pc_o,
  output logic [INST_W-1:0] if_id_inst_o,
  output logic              if_id_valid_o,
  output logic              misalign_o,
  output logic [CNT_W-1:0]  fetch_cnt_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic              id_valid_q, id_valid_d;
  logic              mis_q, mis_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] tgt_pc;
  logic              tgt_mis;

  // Targets are forced word aligned; the dropped bits raise misalign.
  assign tgt_pc  = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign tgt_mis = |redirect_pc_i[1:0];

  assign rom_addr_o = {2'b00, pc_q[ADDR_W-1:2]};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    mis_d      = 1'b0;
    cnt_d      = cnt_q;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        if (redirect_i) begin
          pc_d  = tgt_pc;
          mis_d = tgt_mis;
        end
      end
      RUN: begin
        if (redirect_i) begin
          pc_d       = tgt_pc;
          mis_d      = tgt_mis;
          id_pc_d    = '0;
          id_inst_d  = NOP;
          id_valid_d = 1'b0;
        end else if (halt_i) begin
          state_d    = HALT;
          id_pc_d    = '0;
          id_inst_d  = NOP;
          id_valid_d = 1'b0;
        end else if (!stall_i) begin
          id_pc_d    = pc_q;
          id_inst_d  = inst_i;
          id_valid_d = 1'b1;
          pc_d       = pc_q + ADDR_W'(4);
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end
      HALT: begin
        id_pc_d    = '0;
        id_inst_d  = NOP;
        id_valid_d = 1'b0;
        if (redirect_i) begin
          state_d = RUN;
          pc_d    = tgt_pc;
          mis_d   = tgt_mis;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_inst_q  <= NOP;
      id_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
      mis_q      <= mis_d;
      cnt_q      <= cnt_d;
    end
  end

  assign if_id_pc_o    = id_pc_q;
  assign if_id_inst_o  = id_inst_q;
  assign if_id_valid_o = id_valid_q;
  assign misalign_o    = mis_q;
  assign fetch_cnt_o   = cnt_q;

endmodule
